// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug UART transmit port.
// STATUS layout: busy, full, empty, overflow, saturated count.
package debug_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 4;

  localparam logic [31:0] STATUS_OFFSET = 32'd4;

  // The lowest enabled byte lane carries the character.
  function automatic logic [7:0] select_lane(input logic [31:0] data,
                                             input logic [3:0]  we);
    if (we[0])      return data[7:0];
    else if (we[1]) return data[15:8];
    else if (we[2]) return data[23:16];
    else if (we[3]) return data[31:24];
    else            return 8'h00;
  endfunction

  function automatic logic [3:0] sat_count(input logic [31:0] c);
    return (c > 32'd15) ? 4'hf : c[3:0];
  endfunction

endpackage

// File: rtl/debug_uart_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers for full/empty detection.
// A push while full is taken only when a pop happens in the same cycle.
module debug_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Memory-mapped debug character port: byte stores are queued and sent 8N1, LSB first.
// Build option DEBUG_UART_TX_STALL_EN stalls the core on a full FIFO instead of dropping.
module debug_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hf00000d0,
  parameter int          CLKS_PER_BIT = 217,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  data_w_i,
  input  logic        data_access_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        tx_o,
  output logic        irq_o
);

  import debug_uart_pkg::*;

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam int          CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFFSET;

  logic        data_wr;
  logic        status_rd;
  logic        push;
  logic        pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        overflow;

  tx_state_t   state, next_state;
  logic [CW-1:0] baud_cnt, next_baud;
  logic [2:0]  bit_idx, next_idx;
  logic [7:0]  shift, next_shift;
  logic        tx_q, next_tx;
  logic        irq_q;
  logic        bit_done;
  logic [31:0] status;

  assign data_wr   = data_access_i && (address_i == BASE_ADDR) && (data_w_i != 4'b0000);
  assign status_rd = data_access_i && (address_i == STATUS_ADDR) && (data_w_i == 4'b0000);
  assign push      = data_wr && (!fifo_full || pop);

  debug_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (select_lane(data_i, data_w_i)),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef DEBUG_UART_TX_STALL_EN
  // Hold the core until the transmitter frees a slot; nothing is ever dropped.
  assign stall_o  = data_wr && fifo_full && !pop;
  assign overflow = 1'b0;
`else
  logic status_wr;

  assign stall_o   = 1'b0;
  assign status_wr = data_access_i && (address_i == STATUS_ADDR) && (data_w_i != 4'b0000);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overflow <= 1'b0;
    else if (status_wr)
      overflow <= 1'b0;
    else if (data_wr && fifo_full && !pop)
      overflow <= 1'b1;
  end
`endif

  assign bit_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    next_state = state;
    next_baud  = baud_cnt;
    next_idx   = bit_idx;
    next_shift = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_shift = fifo_rdata;
          next_state = START;
          next_baud  = '0;
        end
      end
      START: begin
        if (bit_done) begin
          next_state = DATA;
          next_baud  = '0;
          next_idx   = 3'd0;
        end else begin
          next_baud = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          next_baud = '0;
          if (bit_idx == 3'd7) next_state = STOP;
          else                 next_idx   = bit_idx + 3'd1;
        end else begin
          next_baud = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          next_state = IDLE;
          next_baud  = '0;
        end else begin
          next_baud = baud_cnt + CW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The line level is registered from the next state so tx_o is glitch-free.
  always_comb begin
    next_tx = 1'b1;
    case (next_state)
      START:   next_tx = 1'b0;
      DATA:    next_tx = next_shift[next_idx];
      default: next_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
    end else begin
      state    <= next_state;
      baud_cnt <= next_baud;
      bit_idx  <= next_idx;
      shift    <= next_shift;
      tx_q     <= next_tx;
      irq_q    <= fifo_empty && (state == IDLE);
    end
  end

  always_comb begin
    status                            = 32'h0;
    status[STAT_BUSY]                 = (state != IDLE);
    status[STAT_FULL]                 = fifo_full;
    status[STAT_EMPTY]                = fifo_empty;
    status[STAT_OVERFLOW]             = overflow;
    status[STAT_COUNT_LSB +: 4]       = sat_count(32'(fifo_count));
  end

  assign data_o = status_rd ? status : 32'h0;
  assign tx_o   = tx_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a UART line monitor.
// Expectations follow DEBUG_UART_TX_STALL_EN when it is defined for the build.
module tb_debug_uart_tx;

  localparam logic [31:0] BASE = 32'hf00000d0;
  localparam logic [31:0] STAT = 32'hf00000d4;
  localparam int          NV   = 10;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
    logic [7:0]  exp_byte;
    bit          sends;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address_i = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic [3:0]  data_w_i = 4'h0;
  logic        data_access_i = 1'b0;
  logic [31:0] data_o;
  logic        stall_o;
  logic        tx_o;
  logic        irq_o;

  int checks = 0;
  int passed = 0;
  int cycle = 0;

  debug_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address_i     (address_i),
    .data_i        (data_i),
    .data_w_i      (data_w_i),
    .data_access_i (data_access_i),
    .data_o        (data_o),
    .stall_o       (stall_o),
    .tx_o          (tx_o),
    .irq_o         (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Line monitor: samples each bit a cycle into its 4-cycle slot, aborts on reset.
  logic [7:0] rx_bytes[$];
  int         rx_start[$];
  int         frame_err = 0;
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_t = 0;
  logic [7:0] rx_shift = 8'h00;

  always @(negedge clk) begin
    if (!reset_n) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx_o == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_t      = cycle;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0) begin
        rx_shift[3'((rx_cnt - 5) / 4)] = tx_o;
      end else if (rx_cnt == 37) begin
        if (tx_o !== 1'b1) frame_err++;
        rx_bytes.push_back(rx_shift);
        rx_start.push_back(rx_t);
        rx_active = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    address_i     = addr;
    data_i        = data;
    data_w_i      = we;
    data_access_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic idleBus();
    address_i     = 32'h0;
    data_i        = 32'h0;
    data_w_i      = 4'h0;
    data_access_i = 1'b0;
  endtask

  task automatic readStatus(input string name, input logic [31:0] expected);
    address_i     = STAT;
    data_w_i      = 4'h0;
    data_access_i = 1'b1;
    #1;
    checkOutput(name, data_o, expected);
    idleBus();
  endtask

  task automatic waitRx(input int target, input int budget, input string name);
    int n = 0;
    while (rx_bytes.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " rx count"}, 32'(rx_bytes.size()), 32'(target));
  endtask

  function automatic logic [7:0] wrap_byte(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  vec_t vecs[NV];

  initial begin
    int base;
    int n;
    int k;
    int grp;
    int nburst;

    vecs[0] = '{BASE,         32'h00000041, 4'b0001, 8'h41, 1'b1};
    vecs[1] = '{BASE,         32'h5A000000, 4'b1000, 8'h5A, 1'b1};
    vecs[2] = '{BASE,         32'h0000C300, 4'b0010, 8'hC3, 1'b1};
    vecs[3] = '{BASE,         32'h00A50000, 4'b0100, 8'hA5, 1'b1};
    vecs[4] = '{BASE,         32'h12345678, 4'b1111, 8'h78, 1'b1};
    vecs[5] = '{BASE,         32'h12345678, 4'b1100, 8'h34, 1'b1};
    vecs[6] = '{BASE,         32'h12345678, 4'b1010, 8'h56, 1'b1};
    vecs[7] = '{BASE + 32'd8, 32'h000000AA, 4'b0001, 8'h00, 1'b0};
    vecs[8] = '{STAT,         32'h000000BB, 4'b0001, 8'h00, 1'b0};
    vecs[9] = '{BASE,         32'h000000CC, 4'b0000, 8'h00, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset tx_o", tx_o, 1);
    checkOutput("reset irq_o", irq_o, 1);
    checkOutput("reset stall_o", stall_o, 0);
    checkOutput("reset data_o", data_o, 0);
    reset_n = 1'b1;
    @(negedge clk);
    readStatus("reset status", 32'h04);
    address_i = BASE; data_w_i = 4'h0; data_access_i = 1'b1;
    #1 checkOutput("data addr read zero", data_o, 0);
    idleBus();

    // Single byte with start-bit latency
    @(negedge clk);
    base = rx_bytes.size();
    applyStimulus(BASE, 32'h41, 4'b0001);
    idleBus();
    checkOutput("single tx high at +1", tx_o, 1);
    @(negedge clk);
    checkOutput("single tx low at +2", tx_o, 0);
    checkOutput("single irq low", irq_o, 0);
    readStatus("single status busy", 32'h05);
    waitRx(base + 1, 60, "single");
    checkOutput("single byte", rx_bytes[base], 8'h41);
    repeat (6) @(negedge clk);
    checkOutput("single irq after", irq_o, 1);
    readStatus("single status after", 32'h04);

    // Lane select and address decode vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      base = rx_bytes.size();
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].we);
      idleBus();
      if (vecs[i].sends) begin
        waitRx(base + 1, 60, $sformatf("vec %0d", i));
        checkOutput($sformatf("vec %0d byte", i), rx_bytes[base], vecs[i].exp_byte);
        repeat (6) @(negedge clk);
      end else begin
        repeat (50) @(negedge clk);
        checkOutput($sformatf("vec %0d no frame", i), 32'(rx_bytes.size()), 32'(base));
      end
    end

    // Burst of six back-to-back stores into a four-entry FIFO
    @(negedge clk);
    base = rx_bytes.size();
    for (int i = 0; i < 5; i++) applyStimulus(BASE, 32'h10 + 32'(i), 4'b0001);
    address_i = BASE; data_i = 32'h15; data_w_i = 4'b0001; data_access_i = 1'b1;
    #1;
`ifdef DEBUG_UART_TX_STALL_EN
    nburst = 6;
    checkOutput("burst stall asserted", stall_o, 1);
    n = 0;
    while (stall_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("burst stall released", stall_o, 0);
    @(negedge clk);
    idleBus();
    readStatus("burst status", 32'h43);
`else
    nburst = 5;
    checkOutput("burst no stall", stall_o, 0);
    @(negedge clk);
    idleBus();
    readStatus("burst status overflow", 32'h4B);
`endif
    applyStimulus(STAT, 32'h0, 4'b0001);
    idleBus();
    readStatus("burst overflow cleared", 32'h43);
    waitRx(base + nburst, 400, "burst");
    for (int i = 0; i < nburst; i++)
      checkOutput($sformatf("burst byte %0d", i), rx_bytes[base + i], 8'h10 + 8'(i));
    for (int i = 1; i < nburst; i++)
      checkOutput($sformatf("burst spacing %0d", i),
                  32'(rx_start[base + i] - rx_start[base + i - 1]), 32'd41);
    repeat (6) @(negedge clk);

    // STATUS polling mid-transmission
    base = rx_bytes.size();
    applyStimulus(BASE, 32'h77, 4'b0001);
    applyStimulus(BASE, 32'h88, 4'b0001);
    idleBus();
    repeat (8) @(negedge clk);
    readStatus("poll mid-frame", 32'h11);
    applyStimulus(STAT, 32'h0, 4'b1111);
    idleBus();
    readStatus("poll after status write", 32'h11);
    waitRx(base + 2, 120, "poll");
    checkOutput("poll byte 0", rx_bytes[base], 8'h77);
    checkOutput("poll byte 1", rx_bytes[base + 1], 8'h88);
    repeat (6) @(negedge clk);

    // Reset during data bit 3 of a zero byte, with more bytes queued
    base = rx_bytes.size();
    applyStimulus(BASE, 32'h00, 4'b0001);
    applyStimulus(BASE, 32'h55, 4'b0001);
    applyStimulus(BASE, 32'h66, 4'b0001);
    idleBus();
    repeat (16) @(negedge clk);
    checkOutput("pre-reset tx low", tx_o, 0);
    #2 reset_n = 1'b0;
    #1 checkOutput("reset tx async high", tx_o, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    readStatus("post-reset status", 32'h04);
    checkOutput("post-reset irq", irq_o, 1);
    repeat (60) @(negedge clk);
    checkOutput("no residual frame", 32'(rx_bytes.size()), 32'(base));
    checkOutput("post-reset tx idle", tx_o, 1);

    // Twenty stores in groups of three to wrap the pointers
    base = rx_bytes.size();
    k = 0;
    while (k < 20) begin
      grp = (20 - k < 3) ? (20 - k) : 3;
      for (int j = 0; j < grp; j++) applyStimulus(BASE, 32'(wrap_byte(k + j)), 4'b0001);
      idleBus();
      k += grp;
      waitRx(base + k, 200, $sformatf("wrap group %0d", k));
      repeat (6) @(negedge clk);
    end
    for (int i = 0; i < 20; i++)
      checkOutput($sformatf("wrap byte %0d", i), rx_bytes[base + i], wrap_byte(i));

    checkOutput("stop bits", 32'(frame_err), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
- Memory-mapped debug output port for the hf-riscv core.
- Accepts CPU byte stores to a fixed debug address and buffers them in a small FIFO.
- Serializes buffered bytes onto a UART TX line, 8N1, LSB first.
- It is the hardware transmit end of the debug character stream that the bench's UART monitor captures to a file. The bench reconstructs bytes from tx_o and compares them against the store stream.

Parameters:
- BASE_ADDR, 32'hf00000d0, address of the DATA register. STATUS is at BASE_ADDR+4.
- CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200). Minimum 2.
- FIFO_DEPTH, 8, byte entries. Power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address_i  in  32  core data address
- data_i  in  32  core store data
- data_w_i  in  4  byte write enables; nonzero means a write
- data_access_i  in  1  data bus access valid this cycle
- data_o  out  32  read data; STATUS when address matches, else 0
- stall_o  out  1  stall request to the core
- tx_o  out  1  UART serial line, idles high
- irq_o  out  1  level interrupt, FIFO empty and line idle

Behaviour:
- Reset (async assert, sync release): tx_o=1, stall_o=0, data_o=0, irq_o=1, FIFO empty, FSM IDLE, baud counter 0.
- DATA write:
  - Condition: data_access_i && address_i==BASE_ADDR && data_w_i!=0.
  - Byte taken from the lane of the lowest set enable bit, e.g. data_w_i=4'b1000 takes data_i[31:24].
  - Pushed at the rising edge if the FIFO is not full.
- STATUS read (data_access_i && address_i==BASE_ADDR+4 && data_w_i==0), data_o is combinational:
  - [0] busy (FSM not IDLE)
  - [1] full
  - [2] empty
  - [3] overflow (sticky)
  - [7:4] count, saturating at 15
  - [31:8] 0
- Writes to BASE_ADDR+4 clear overflow. All other addresses are ignored.
- FSM states:
  - IDLE: tx_o=1. If the FIFO is not empty, pop into the shift register, go to START, reset the baud counter.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx_o=shift[idx] for CLKS_PER_BIT cycles each, idx 0..7. After idx 7, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then IDLE. A new start bit can follow on the next cycle, so back-to-back frames are 10*CLKS_PER_BIT+1 cycles.
- Latency: a store accepted at edge N is in the FIFO after N. The FSM pops at edge N+1, and tx_o falls after edge N+1 (two cycles from the request cycle).
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - A push to a full FIFO in the same cycle as a pop is accepted.
- Wrap-around: pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from pointer MSB compare.
- irq_o = empty && FSM IDLE, registered.
- Reset mid-frame: the frame is aborted, tx_o goes high immediately (asynchronously), and FIFO contents are lost.

Optional Feature:
- Macro: DEBUG_UART_TX_STALL_EN.
- Defined:
  - A DATA write to a full FIFO (without a simultaneous pop) asserts stall_o combinationally.
  - The write is held until space frees, then accepted and stall_o drops.
  - overflow never sets.
- Undefined:
  - stall_o is tied to 0.
  - A write to a full FIFO is dropped and overflow is set, sticky until a STATUS write or reset.

Decomposition:
- Package debug_uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t
  - STATUS bit-index localparams
  - STATUS_OFFSET = 4
- One sub-module: debug_uart_fifo, a synchronous byte FIFO.
  - Parameter: DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, count.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: store 0x41 with data_w_i=0001 -> tx_o low at cycle +2, then bits 1,0,0,0,0,0,1,0, then stop high; 40 cycles of frame; busy=1 during the frame; irq_o=1 after.
- Lane select: store data_i=32'h5A000000 with data_w_i=1000 -> serialized byte 0x5A.
- Burst of 6 stores back-to-back:
  - With STALL_EN: stall_o asserts on the 6th store (5th is accepted since the pop occurred); all 6 bytes are transmitted in order, back-to-back frames 41 cycles apart.
  - Without STALL_EN: STATUS overflow=1 and exactly 5 bytes are transmitted.
- STATUS polling: after 2 stores, read BASE_ADDR+4 mid-transmission -> busy=1, empty=0, count=1; after a STATUS write, overflow=0.
- Reset mid-frame: assert reset_n low during DATA bit 3 -> tx_o=1 within the same cycle; after release, empty=1, irq_o=1, and no residual frame.
- Wrap-around: 20 stores in groups of 3 -> all 20 bytes are received intact, covering pointer wrap multiple times.
